// File: rtl/modport_arb_pkg.sv
// modport_arb_pkg: shared state encoding and index helpers for the round-robin arbiter
package modport_arb_pkg;
  localparam int N_MAX = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, COOL = 2'd2} state_t;
  function automatic logic [N_MAX-1:0] onehot(input int idx);
    return N_MAX'(1) << idx;
  endfunction
  function automatic int next_ptr(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/arb_if.sv
// arb_if: one requester's view of the arbiter, exposed through a modport with expression items
interface arb_if #(parameter int WIDTH = 8);
  logic             req_l;
  logic [WIDTH-1:0] data_l;
  logic             gnt_l;
  modport req_mp(output .req(req_l), output .data(data_l), input .gnt(gnt_l));
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [N-1:0] rot;
  assign rot = N'({req, req} >> ptr);
  always_comb begin
    found = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) idx = IW'((int'(ptr) + k) % N);
  end
endmodule

// File: rtl/modport_rr_arbiter.sv
// modport_rr_arbiter: round-robin owner of a shared bus with hold limit and one-cycle turnaround
module modport_rr_arbiter
  import modport_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic [WIDTH-1:0]     bus_data,
  output logic                 timeout
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD + 1);
  state_t        state;
  logic [IW-1:0] ptr, pick;
  logic [HW-1:0] hold_cnt;
  logic          found;
  rr_pick #(.N(N), .IW(IW)) u_pick (.req(req), .ptr(ptr), .found(found), .idx(pick));
  assign bus_data = busy ? req_data[owner*WIDTH +: WIDTH] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: if (found) begin
          state <= GRANT;
          gnt <= N'(onehot(int'(pick)));
          owner <= pick;
          busy <= 1'b1;
          hold_cnt <= '0;
        end
        GRANT: begin
          hold_cnt <= (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
          if (!req[owner] || hold_cnt == HW'(MAX_HOLD - 1)) begin
            state <= COOL;
            gnt <= '0;
            busy <= 1'b0;
            timeout <= req[owner];
            ptr <= IW'(next_ptr(int'(owner), N));
          end
        end
        default: begin
          state <= IDLE;
          owner <= '0;
        end
      endcase
    end
  end
endmodule
